canny_pixel_streamer: RTL and testbench
=======================================

Name: canny_pixel_streamer

Overview:
Frame source that feeds the edge-detection pipeline's pixel input.
- Reads an 8-bit greyscale frame from a synchronous-read memory (1-cycle read latency) in raster order.
- Drives pixel_out/out_valid into the pipeline's pixel_in/in_valid, with optional inter-line blanking.
- After the frame, appends zero-valued flush lines to drain the pipeline's line-buffer stages, then pulses done.

Parameters:
W, 3124, image width in pixels
H, 3030, image height in lines
ADDR_W, 24, frame memory address width; must satisfy 2**ADDR_W >= W*H
LINE_GAP, 0, idle cycles inserted after every emitted line except the last
FLUSH_LINES, 5, zero lines appended after the frame; 5 = one per line-buffer stage

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a frame when idle
abort  in  1  synchronous abort of the frame in progress
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  read address, y*W+x
mem_rdata  in  8  read data, valid the cycle after mem_rd_en
pixel_out  out  8  pixel to pipeline
out_valid  out  1  pixel_out valid, one pixel per asserted cycle
frame_start  out  1  high with pixel (0,0) only
line_end  out  1  high with the last pixel of every line, flush lines included
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final flush pixel

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. All counters and in-flight tags cleared.
- FSM states: IDLE, STREAM, GAP, FLUSH, FLUSH_GAP, FINISH.
- IDLE:
  - start=1 -> STREAM, x=y=0, address counter=0.
  - start is ignored in every other state.
- STREAM:
  - Each cycle asserts mem_rd_en with mem_addr = running address counter. Use an incrementer, no multiplier.
  - x increments. At x=W-1: x wraps to 0 and y increments.
  - After the last pixel of a line: go to GAP if LINE_GAP>0 and the line is not the last emitted line, else continue.
  - After pixel (W-1,H-1): go to FLUSH (or FINISH if FLUSH_LINES=0).
- GAP: no reads for exactly LINE_GAP cycles, then return to STREAM.
- FLUSH:
  - Emits W*FLUSH_LINES pixels of value 0 with no memory read.
  - These pixels pass through the same 2-stage tag pipe, so timing matches real pixels.
  - FLUSH_GAP applies between flush lines under the same LINE_GAP rule.
- Latency:
  - Issue cycle t: mem_rd_en (or flush issue).
  - Cycle t+1: mem_rdata valid.
  - Cycle t+2: registered pixel_out, out_valid, frame_start, line_end.
  - Tags (valid, is_flush, frame_start, line_end) travel with the request through the same 2 stages.
- FINISH: waits until the tag pipe is empty. Then done=1 for 1 cycle, busy=0 in that same cycle, state -> IDLE.
- First issue is the cycle after start. First out_valid is 3 cycles after start.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE, busy=0, mem_rd_en=0.
  - In-flight tags are cleared, so out_valid=0 from the cycle after abort.
  - No done pulse.
  - Abort takes priority over start.
- out_valid, line_end and frame_start are never high in gap cycles. pixel_out holds its last value when out_valid=0.

Decomposition:
- Package canny_pkg holds:
  - enum stream_state_t
  - localparam PIX_W=8
  - A function for the minimum address width, used by an elaboration-time assertion on ADDR_W.
- One natural sub-module: raster_counter (x/y/address counters with wrap and last-pixel flags), reused for STREAM and FLUSH.

Test Plan:
- Use W=4, H=3, LINE_GAP=2, FLUSH_LINES=1, with memory[a]=a+1 for all cases below.
1. Start at cycle 0 -> mem_addr 0..11 issued in order. out_valid first at cycle 3. pixel_out sequence 1..12 then 0,0,0,0. frame_start only with value 1.
2. Same run -> out_valid drops for exactly 2 cycles after each 4-pixel line (3 gaps). line_end on pixels 4, 8, 12 and the final flush 0. Last out_valid at cycle 24. done=1 and busy=0 at cycle 25 only.
3. LINE_GAP=0 -> 16 consecutive out_valid cycles (cycles 3-18). done at cycle 19.
4. abort at cycle 7 (mid line 1) -> out_valid=0 from cycle 8 onward, no done. A new start at cycle 12 restarts at mem_addr 0 with frame_start on value 1.
5. rst_n=0 asynchronously mid-frame -> all outputs 0 before the next clock edge. After release, the block idles until start.
6. start pulses at cycles 5 and 10 during a frame -> ignored, single frame output. start the cycle after done -> a second identical frame.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and helpers for the canny pixel streamer.
//   stream_state_t : sequencer states
//   tag_t          : sideband that travels with each issued pixel request
//   PIX_W          : greyscale pixel width
//   bits_for       : counter width able to hold the values 0..n-1
//   min_addr_w     : smallest address width that covers a w x h frame
package canny_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STREAM    = 3'd1,
    GAP       = 3'd2,
    FLUSH     = 3'd3,
    FLUSH_GAP = 3'd4,
    FINISH    = 3'd5
  } stream_state_t;

  typedef struct packed {
    logic valid;
    logic is_flush;
    logic frame_start;
    logic line_end;
  } tag_t;

  function automatic int bits_for(input longint n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int min_addr_w(input longint w, input longint h);
    return bits_for(w * h);
  endfunction

endpackage

// File: rtl/canny_pixel_streamer_if.sv
// Bus bundle between the streamer, its frame memory and the edge pipeline.
//   mem_rd_en / mem_addr : read request to the frame memory
//   mem_rdata            : read data, one cycle after mem_rd_en
//   pixel_out / out_valid / frame_start / line_end : pixel stream to the pipeline
// master = streamer side, slave = memory/pipeline side.
interface canny_pixel_streamer_if #(
  parameter int ADDR_W = 24
) ();
  import canny_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  pixel_out;
  logic              out_valid;
  logic              frame_start;
  logic              line_end;

  modport master (
    output mem_rd_en, mem_addr, pixel_out, out_valid, frame_start, line_end,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd_en, mem_addr, pixel_out, out_valid, frame_start, line_end,
    output mem_rdata
  );
endinterface

// File: rtl/raster_counter.sv
// Raster-order position counter shared by the frame and flush regions.
//   clear       : force x = y = addr = 0 (priority over advance)
//   advance     : step one pixel in raster order
//   last_y      : index of the final line of the region being walked
//   x, y, addr  : current column, line and linear address y*W+x
//   line_last   : current pixel is the last one of its line
//   region_last : current pixel is the last one of the region
// Stepping past region_last wraps everything to zero, so the counter is
// already positioned for the next region without an explicit clear.
module raster_counter
  import canny_pkg::*;
#(
  parameter int W      = 3124,
  parameter int Y_W    = 12,
  parameter int ADDR_W = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          advance,
  input  logic [Y_W-1:0]                last_y,
  output logic [bits_for(W)-1:0]        x,
  output logic [Y_W-1:0]                y,
  output logic [ADDR_W-1:0]             addr,
  output logic                          line_last,
  output logic                          region_last
);
  localparam int X_W = bits_for(W);
  localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);

  logic [X_W-1:0]    x_reg;
  logic [Y_W-1:0]    y_reg;
  logic [ADDR_W-1:0] addr_reg;

  assign x           = x_reg;
  assign y           = y_reg;
  assign addr        = addr_reg;
  assign line_last   = (x_reg == X_LAST);
  assign region_last = line_last && (y_reg == last_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      addr_reg <= '0;
    end else if (clear) begin
      x_reg    <= '0;
      y_reg    <= '0;
      addr_reg <= '0;
    end else if (advance) begin
      if (region_last) begin
        x_reg    <= '0;
        y_reg    <= '0;
        addr_reg <= '0;
      end else if (line_last) begin
        x_reg    <= '0;
        y_reg    <= y_reg + Y_W'(1);
        addr_reg <= addr_reg + ADDR_W'(1);
      end else begin
        x_reg    <= x_reg + X_W'(1);
        addr_reg <= addr_reg + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/canny_pixel_streamer.sv
// Frame source for the edge-detection pipeline.
// Reads a W x H greyscale frame in raster order from a 1-cycle-latency
// memory, emits it as a pixel stream with optional inter-line blanking,
// then appends FLUSH_LINES zero lines and pulses done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a frame (only honoured when idle)
//   abort        : drop the frame in progress (wins over start)
//   busy         : frame in progress
//   done         : one-cycle pulse after the last flush pixel
//   bus (master) : memory read port and pixel output stream
// Every request (real or flush) carries a tag through two register stages
// so that output timing is identical for memory and flush pixels.
module canny_pixel_streamer
  import canny_pkg::*;
#(
  parameter int W           = 3124,
  parameter int H           = 3030,
  parameter int ADDR_W      = 24,
  parameter int LINE_GAP    = 0,
  parameter int FLUSH_LINES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  canny_pixel_streamer_if.master bus
);
  localparam int X_W   = bits_for(W);
  localparam int Y_W   = bits_for((H > FLUSH_LINES) ? H : FLUSH_LINES);
  localparam int GAP_W = bits_for(LINE_GAP);

  localparam logic [Y_W-1:0]   LAST_Y_IMG   = Y_W'(H - 1);
  localparam logic [Y_W-1:0]   LAST_Y_FLUSH = Y_W'((FLUSH_LINES > 0) ? FLUSH_LINES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_INIT     = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  generate
    if (ADDR_W < min_addr_w(W, H)) begin : g_addr_too_small
      $error("canny_pixel_streamer: ADDR_W cannot address a W*H frame");
    end
  endgenerate

  stream_state_t    state_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  tag_t             tag0;
  tag_t             tag1_reg;
  logic             out_valid_reg;
  logic             frame_start_reg;
  logic             line_end_reg;
  logic [PIX_W-1:0] pixel_reg;

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              line_last;
  logic              region_last;
  logic              issuing;
  logic              kill;
  logic [Y_W-1:0]    last_y;

  assign issuing = (state_reg == STREAM) || (state_reg == FLUSH);
  // abort only has meaning while a frame is active
  assign kill    = abort && (state_reg != IDLE);
  assign last_y  = (state_reg == FLUSH) ? LAST_Y_FLUSH : LAST_Y_IMG;

  raster_counter #(
    .W      (W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       ((state_reg == IDLE) || kill),
    .advance     (issuing),
    .last_y      (last_y),
    .x           (x),
    .y           (y),
    .addr        (addr),
    .line_last   (line_last),
    .region_last (region_last)
  );

  // Tag for the request issued this cycle.
  always_comb begin
    tag0             = '0;
    tag0.valid       = issuing;
    tag0.is_flush    = (state_reg == FLUSH);
    tag0.frame_start = (state_reg == STREAM) && (x == '0) && (y == '0);
    tag0.line_end    = issuing && line_last;
  end

  // Sequencer. The final image line is followed by FLUSH_GAP rather than
  // GAP so that blanking before the first flush line returns to FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (kill) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg <= STREAM;
              busy_reg  <= 1'b1;
            end
          end
          STREAM: begin
            if (line_last) begin
              if (region_last) begin
                if (FLUSH_LINES == 0) begin
                  state_reg <= FINISH;
                end else if (LINE_GAP > 0) begin
                  state_reg   <= FLUSH_GAP;
                  gap_cnt_reg <= GAP_INIT;
                end else begin
                  state_reg <= FLUSH;
                end
              end else if (LINE_GAP > 0) begin
                state_reg   <= GAP;
                gap_cnt_reg <= GAP_INIT;
              end
            end
          end
          GAP: begin
            if (gap_cnt_reg == '0) state_reg <= STREAM;
            else gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
          FLUSH: begin
            if (line_last) begin
              if (region_last) begin
                state_reg <= FINISH;
              end else if (LINE_GAP > 0) begin
                state_reg   <= FLUSH_GAP;
                gap_cnt_reg <= GAP_INIT;
              end
            end
          end
          FLUSH_GAP: begin
            if (gap_cnt_reg == '0) state_reg <= FLUSH;
            else gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
          FINISH: begin
            // Once stage 1 is empty the last pixel is on the output this
            // cycle, so done lands exactly one cycle after it.
            if (!tag1_reg.valid) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Two-stage tag pipe: stage 1 lines up with mem_rdata, stage 2 is the
  // registered output. pixel_out holds when nothing valid arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_reg        <= '0;
      out_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
      pixel_reg       <= '0;
    end else if (kill) begin
      tag1_reg        <= '0;
      out_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
    end else begin
      tag1_reg        <= tag0;
      out_valid_reg   <= tag1_reg.valid;
      frame_start_reg <= tag1_reg.valid && tag1_reg.frame_start;
      line_end_reg    <= tag1_reg.valid && tag1_reg.line_end;
      if (tag1_reg.valid) begin
        pixel_reg <= tag1_reg.is_flush ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_rd_en   = (state_reg == STREAM);
  assign bus.mem_addr    = addr;
  assign bus.pixel_out   = pixel_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.line_end    = line_end_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
endmodule

// File: tb/tb_canny_pixel_streamer.sv
// Bench for canny_pixel_streamer: two instances (LINE_GAP=2 and LINE_GAP=0)
// on a 4x3 frame with one flush line, driven by the same start/abort table.
// Expected per-cycle outputs come from a frame-level timing model.
module tb_canny_pixel_streamer;
  localparam int TW   = 4;
  localparam int TH   = 3;
  localparam int TF   = 1;
  localparam int TA   = 8;
  localparam int NL   = TH + TF;
  localparam int NCYC = 64;

  typedef struct {
    bit rd;
    int addr;
    bit valid;
    int pix;
    bit fs;
    bit le;
    bit busy;
    bit done;
  } exp_t;

  typedef struct {
    bit   start;
    bit   abort;
    exp_t ea;
    exp_t eb;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [7:0] mem [16];

  int   checks = 0;
  int   errors = 0;
  int   last_pix [2];
  vec_t vec [NCYC];

  canny_pixel_streamer_if #(.ADDR_W(TA)) bus_a ();
  canny_pixel_streamer_if #(.ADDR_W(TA)) bus_b ();

  canny_pixel_streamer #(
    .W(TW), .H(TH), .ADDR_W(TA), .LINE_GAP(2), .FLUSH_LINES(TF)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  canny_pixel_streamer #(
    .W(TW), .H(TH), .ADDR_W(TA), .LINE_GAP(0), .FLUSH_LINES(TF)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // frame memory, 1-cycle read latency
  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem[bus_a.mem_addr[3:0]];
    if (bus_b.mem_rd_en) bus_b.mem_rdata <= mem[bus_b.mem_addr[3:0]];
  end

  task automatic cmp(input string nm, input int c, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, c, got, want);
    end
  endtask

  task automatic check_dut(input string nm, input int c, input exp_t e,
                           input logic rd, input logic [TA-1:0] addr,
                           input logic valid, input logic [7:0] pix,
                           input logic fs, input logic le,
                           input logic bsy, input logic dn);
    cmp({nm, ".mem_rd_en"}, c, int'(rd), int'(e.rd));
    if (e.rd) cmp({nm, ".mem_addr"}, c, int'(addr), e.addr);
    cmp({nm, ".out_valid"}, c, int'(valid), int'(e.valid));
    cmp({nm, ".pixel_out"}, c, int'(pix), e.pix);
    cmp({nm, ".frame_start"}, c, int'(fs), int'(e.fs));
    cmp({nm, ".line_end"}, c, int'(le), int'(e.le));
    cmp({nm, ".busy"}, c, int'(bsy), int'(e.busy));
    cmp({nm, ".done"}, c, int'(dn), int'(e.done));
  endtask

  task automatic check_zero(input string nm);
    cmp({nm, "/a.mem_rd_en"}, -1, int'(bus_a.mem_rd_en), 0);
    cmp({nm, "/a.mem_addr"}, -1, int'(bus_a.mem_addr), 0);
    cmp({nm, "/a.pixel_out"}, -1, int'(bus_a.pixel_out), 0);
    cmp({nm, "/a.out_valid"}, -1, int'(bus_a.out_valid), 0);
    cmp({nm, "/a.frame_start"}, -1, int'(bus_a.frame_start), 0);
    cmp({nm, "/a.line_end"}, -1, int'(bus_a.line_end), 0);
    cmp({nm, "/a.busy"}, -1, int'(busy_a), 0);
    cmp({nm, "/a.done"}, -1, int'(done_a), 0);
    cmp({nm, "/b.mem_rd_en"}, -1, int'(bus_b.mem_rd_en), 0);
    cmp({nm, "/b.mem_addr"}, -1, int'(bus_b.mem_addr), 0);
    cmp({nm, "/b.pixel_out"}, -1, int'(bus_b.pixel_out), 0);
    cmp({nm, "/b.out_valid"}, -1, int'(bus_b.out_valid), 0);
    cmp({nm, "/b.busy"}, -1, int'(busy_b), 0);
    cmp({nm, "/b.done"}, -1, int'(done_b), 0);
  endtask

  // Frame-level model: an accepted start at cycle s issues line k pixel i
  // at s+1+k*(W+gap)+i, shows it 2 cycles later, done follows the last
  // pixel by one cycle. Abort erases everything after its cycle.
  task automatic model(input int gap, input int idx);
    exp_t e [NCYC];
    int   done_c;
    int   last;
    int   t;
    int   p;
    done_c = -1;
    for (int c = 0; c < NCYC; c++) e[c] = '{default: 0};
    for (int c = 0; c < NCYC; c++) begin
      if (vec[c].abort && e[c].busy) begin
        for (int k = c + 1; k <= done_c && k < NCYC; k++) begin
          e[k].rd    = 0;
          e[k].valid = 0;
          e[k].fs    = 0;
          e[k].le    = 0;
          e[k].busy  = 0;
          e[k].done  = 0;
        end
      end else if (vec[c].start && !e[c].busy) begin
        for (int k = 0; k < NL; k++) begin
          for (int i = 0; i < TW; i++) begin
            t = c + 1 + k * (TW + gap) + i;
            if (k < TH && t < NCYC) begin
              e[t].rd   = 1;
              e[t].addr = k * TW + i;
            end
            if (t + 2 < NCYC) begin
              e[t+2].valid = 1;
              e[t+2].pix   = (k < TH) ? int'(mem[k*TW+i]) : 0;
              e[t+2].fs    = (k == 0 && i == 0);
              e[t+2].le    = (i == TW - 1);
            end
          end
        end
        last = c + 1 + (NL - 1) * (TW + gap) + TW - 1;
        for (int b = c + 1; b <= last + 2 && b < NCYC; b++) e[b].busy = 1;
        done_c = last + 3;
        if (done_c < NCYC) e[done_c].done = 1;
      end
    end
    p = last_pix[idx];
    for (int c = 0; c < NCYC; c++) begin
      if (e[c].valid) p = e[c].pix;
      else e[c].pix = p;
    end
    last_pix[idx] = p;
    for (int c = 0; c < NCYC; c++) begin
      if (idx == 0) vec[c].ea = e[c];
      else vec[c].eb = e[c];
    end
  endtask

  task automatic clear_vec();
    for (int c = 0; c < NCYC; c++) begin
      vec[c].start = 0;
      vec[c].abort = 0;
    end
  endtask

  task automatic ramp_mem();
    for (int a = 0; a < 16; a++) mem[a] = 8'(a + 1);
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_scenario(input string nm);
    int e0;
    e0 = errors;
    model(2, 0);
    model(0, 1);
    for (int c = 0; c < NCYC; c++) begin
      start = vec[c].start;
      abort = vec[c].abort;
      @(negedge clk);
      check_dut({nm, "/a"}, c, vec[c].ea, bus_a.mem_rd_en, bus_a.mem_addr,
                bus_a.out_valid, bus_a.pixel_out, bus_a.frame_start,
                bus_a.line_end, busy_a, done_a);
      check_dut({nm, "/b"}, c, vec[c].eb, bus_b.mem_rd_en, bus_b.mem_addr,
                bus_b.out_valid, bus_b.pixel_out, bus_b.frame_start,
                bus_b.line_end, busy_b, done_b);
      @(posedge clk);
      #1;
    end
    start = 0;
    abort = 0;
    $display("scenario %s: %0d cycles, new errors %0d", nm, NCYC, errors - e0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    last_pix[0] = 0;
    last_pix[1] = 0;
    ramp_mem();

    rst_n = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full frame, gap and no-gap timing, flush and done
    clear_vec();
    vec[0].start = 1;
    run_scenario("frame");

    // abort mid line 1, then a fresh start
    clear_vec();
    vec[0].start  = 1;
    vec[7].abort  = 1;
    vec[12].start = 1;
    run_scenario("abort_restart");

    // starts during a frame are ignored; start right after done restarts
    clear_vec();
    vec[0].start  = 1;
    vec[5].start  = 1;
    vec[10].start = 1;
    vec[20].start = 1;
    vec[26].start = 1;
    run_scenario("ignored_starts");

    // randomized memory contents and start/abort timing
    for (int r = 0; r < 6; r++) begin
      clear_vec();
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom_range(0, 255));
      vec[$urandom_range(0, 5)].start = 1;
      for (int k = 0; k < 3; k++) vec[$urandom_range(0, 11)].start = 1;
      if ($urandom_range(0, 1) == 1) vec[$urandom_range(0, 40)].abort = 1;
      if ($urandom_range(0, 3) == 0) vec[$urandom_range(0, 40)].abort = 1;
      run_scenario($sformatf("random%0d", r));
    end

    // asynchronous reset in the middle of a frame
    ramp_mem();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_pix[0] = 0;
    last_pix[1] = 0;

    clear_vec();
    run_scenario("idle_after_reset");

    clear_vec();
    vec[2].start = 1;
    run_scenario("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
